// File: rtl/dual_bank_mem_responder.sv
// dual_bank_mem_responder: even/odd word banks serving a 64-bit fetch-pair port and a byte-enabled data port
module dual_bank_mem_responder #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr,
  output logic [63:0] inst_out,
  output logic        inst_valid,
  output logic        inst_misalign,
  input  logic        mem_w,
  input  logic [3:0]  dwea,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        busy
);
  localparam int R = ADDR_W - 1;
  localparam int DEPTH = 1 << R;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_d;
  logic run, clr, d_we, unused_bits;
  logic [R-1:0] cnt, i_row, i_row_even, d_row;
  logic [ADDR_W-1:0] iw, dw;
  logic [31:0] d_old, d_merged;
  logic [31:0] even_mem [DEPTH];
  logic [31:0] odd_mem [DEPTH];
  assign iw = inst_addr[ADDR_W+1:2];
  assign dw = data_addr[ADDR_W+1:2];
  assign i_row = iw[ADDR_W-1:1];
  assign i_row_even = i_row + R'(iw[0]);
  assign d_row = dw[ADDR_W-1:1];
  assign d_old = dw[0] ? odd_mem[d_row] : even_mem[d_row];
  assign d_we = mem_w & run & ~rst;
  assign unused_bits = ^{inst_addr[31:ADDR_W+2], data_addr[31:ADDR_W+2], data_addr[1:0]};
  for (genvar l = 0; l < 4; l++) begin : g_lane
    assign d_merged[8*l+:8] = (d_we && dwea[l]) ? data_wdata[8*l+:8] : d_old[8*l+:8];
  end
  // state register; reset always restarts the zero-fill sweep
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else state <= state_d;
  end
  // leave CLEAR once the last row has been zeroed
  always_comb begin
    state_d = (state == CLEAR && &cnt) ? RUN : state;
  end
  // state-derived controls
  always_comb begin
    run = state == RUN;
    clr = ~run;
    busy = ~run;
  end
  // sweep row counter
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (clr) cnt <= cnt + R'(1);
  end
  // even bank: sweep zeroing or byte-lane data write
  always_ff @(posedge clk) begin
    if (clr) even_mem[cnt] <= '0;
    else for (int l = 0; l < 4; l++) if (d_we && !dw[0] && dwea[l]) even_mem[d_row][8*l+:8] <= data_wdata[8*l+:8];
  end
  // odd bank: sweep zeroing or byte-lane data write
  always_ff @(posedge clk) begin
    if (clr) odd_mem[cnt] <= '0;
    else for (int l = 0; l < 4; l++) if (d_we && dw[0] && dwea[l]) odd_mem[d_row][8*l+:8] <= data_wdata[8*l+:8];
  end
  // registered read ports: fetch is read-first, data port is write-first per byte, both zero while sweeping
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_out <= '0;
      inst_valid <= 1'b0;
      inst_misalign <= 1'b0;
      data_rdata <= '0;
    end else begin
      inst_out <= !run ? '0 : iw[0] ? {even_mem[i_row_even], odd_mem[i_row]} : {odd_mem[i_row], even_mem[i_row]};
      inst_valid <= run;
      inst_misalign <= |inst_addr[1:0];
      data_rdata <= run ? d_merged : '0;
    end
  end
endmodule

// File: tb/tb_dual_bank_mem_responder.sv
// tb_dual_bank_mem_responder: randomized scoreboard bench against a word-array reference model
module tb_dual_bank_mem_responder;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] inst_addr, data_addr, data_wdata, data_rdata;
  logic [63:0] inst_out;
  logic inst_valid, inst_misalign, mem_w, busy;
  logic [3:0] dwea;
  typedef struct {
    logic [63:0] inst;
    logic mis;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] model [16];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dual_bank_mem_responder #(.ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_out(inst_out),
    .inst_valid(inst_valid), .inst_misalign(inst_misalign), .mem_w(mem_w),
    .dwea(dwea), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // present one request, predict its response from the word model, and let one clock edge take it
  task automatic issue(input logic [31:0] ia, input logic [31:0] da, input logic w, input logic [3:0] be, input logic [31:0] wd);
    exp_t x;
    int fw, dwi;
    logic [31:0] nw;
    inst_addr = ia; data_addr = da; mem_w = w; dwea = be; data_wdata = wd;
    fw = int'((ia >> 2) % 32'd16);
    dwi = int'((da >> 2) % 32'd16);
    x.inst = {model[(fw + 1) % 16], model[fw]};
    x.mis = ia[1:0] != 2'b00;
    nw = model[dwi];
    for (int l = 0; l < 4; l++) if (w && be[l]) nw[8*l+:8] = wd[8*l+:8];
    x.data = nw;
    model[dwi] = nw;
    q.push_back(x);
    @(posedge clk); #1;
  endtask

  // reset pulse followed by the full zero-fill sweep, with junk writes offered during the sweep
  task automatic reset_seq();
    rst = 1'b1; mem_w = 1'b0; dwea = 4'h0;
    @(posedge clk); #1;
    chk("rst_inst_out", inst_out, 64'h0);
    chk("rst_inst_valid", 64'(inst_valid), 64'h0);
    chk("rst_misalign", 64'(inst_misalign), 64'h0);
    chk("rst_data_rdata", 64'(data_rdata), 64'h0);
    chk("rst_busy", 64'(busy), 64'h1);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      mem_w = 1'b1; dwea = 4'hF; data_addr = $urandom; data_wdata = $urandom; inst_addr = $urandom;
      @(posedge clk); #1;
      chk("sweep_busy", 64'(busy), 64'(i < 8));
      chk("sweep_valid", 64'(inst_valid), 64'h0);
      chk("sweep_rdata", 64'(data_rdata), 64'h0);
      chk("sweep_inst", inst_out, 64'h0);
    end
    mem_w = 1'b0; dwea = 4'h0;
  endtask

  // monitor: every valid response is matched against the oldest prediction
  always @(negedge clk) begin
    if (inst_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid: got valid with empty queue want no response");
      end else begin
        e = q.pop_front();
        chk("inst_out", inst_out, e.inst);
        chk("inst_misalign", 64'(inst_misalign), 64'(e.mis));
        chk("data_rdata", 64'(data_rdata), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    inst_addr = 0; data_addr = 0; mem_w = 0; dwea = 0; data_wdata = 0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_seq();
    for (int i = 0; i < 16; i++) issue(32'(i * 4), 32'(i * 4), 1'b0, 4'h0, 32'h0);
    issue(32'h0, 32'h8, 1'b1, 4'hF, 32'hDEADBEEF);
    issue(32'h0, 32'h8, 1'b1, 4'b0010, 32'h00005500);
    issue(32'h0, 32'h8, 1'b0, 4'h0, 32'h0);
    chk("rmw_word", 64'(data_rdata), 64'hDEAD55EF);
    issue(32'h0, 32'h8, 1'b1, 4'h0, 32'hFFFFFFFF);
    issue(32'h0, 32'h8, 1'b0, 4'h0, 32'h0);
    chk("be0_nochange", 64'(data_rdata), 64'hDEAD55EF);
    issue(32'h0, 32'h0, 1'b1, 4'hF, 32'h11);
    issue(32'h0, 32'h4, 1'b1, 4'hF, 32'h22);
    issue(32'h0, 32'h8, 1'b1, 4'hF, 32'h33);
    issue(32'h0, 32'hC, 1'b1, 4'hF, 32'h44);
    issue(32'h4, 32'h0, 1'b0, 4'h0, 32'h0);
    chk("fetch_4", inst_out, 64'h00000033_00000022);
    issue(32'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    chk("fetch_0", inst_out, 64'h00000022_00000011);
    issue(32'h0, 32'h3C, 1'b1, 4'hF, 32'hAA);
    issue(32'h0, 32'h0, 1'b1, 4'hF, 32'hBB);
    issue(32'h3C, 32'h0, 1'b0, 4'h0, 32'h0);
    chk("fetch_wrap", inst_out, 64'h000000BB_000000AA);
    issue(32'h7C, 32'h0, 1'b0, 4'h0, 32'h0);
    chk("fetch_alias", inst_out, 64'h000000BB_000000AA);
    issue(32'h10, 32'h10, 1'b1, 4'hF, 32'h12345678);
    chk("write_first_data", 64'(data_rdata), 64'h12345678);
    chk("read_first_fetch", 64'(inst_out[31:0]), 64'h0);
    issue(32'h10, 32'h0, 1'b0, 4'h0, 32'h0);
    chk("fetch_after_write", 64'(inst_out[31:0]), 64'h12345678);
    repeat (300) issue($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
    issue(32'h0, 32'h0, 1'b1, 4'hF, 32'hCAFEF00D);
    rst = 1'b1; mem_w = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_seq();
    for (int i = 0; i < 16; i++) begin
      issue(32'(i * 4), 32'(i * 4), 1'b0, 4'h0, 32'h0);
      chk("cleared_word", 64'(data_rdata), 64'h0);
    end
    issue(32'h2, 32'h0, 1'b0, 4'h0, 32'h0);
    chk("misalign_flag", 64'(inst_misalign), 64'h1);
    chk("misalign_pair", inst_out, 64'h0);
    issue(32'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    chk("misalign_not_sticky", 64'(inst_misalign), 64'h0);
    @(negedge clk); #1;
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
